// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller: stalls until the operands are ready, evaluates the
// branch condition, issues a one-cycle redirect on taken branches and keeps saturating counters.
module branch_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_rdy,
  input  logic             rt_rdy,
  input  logic [31:0]      br_target,
  output logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic             wait_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLEZ = 3'd3;
  localparam logic [2:0] OP_BGTZ = 3'd4;
  localparam logic [2:0] OP_BLTZ = 3'd5;
  localparam logic [2:0] OP_BGEZ = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REDIR
  } state_t;

  state_t state, state_nxt;

  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            active, ready, taken, resolve, stall_raw;
  logic            rs_neg, rs_zero;

  assign active  = br_valid && (br_op != 3'd0) && (br_op != 3'd7);
  assign ready   = ((br_op == OP_BEQ) || (br_op == OP_BNE)) ? (rs_rdy && rt_rdy) : rs_rdy;
  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = rs_neg || rs_zero;
      OP_BGTZ: taken = !rs_neg && !rs_zero;
      OP_BLTZ: taken = rs_neg;
      OP_BGEZ: taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stall_raw = 1'b0;
    resolve   = 1'b0;
    case (state)
      S_IDLE: begin
        if (active) begin
          if (ready) begin
            resolve = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_nxt = S_WAIT;
            wait_nxt  = WC_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!active) begin
          state_nxt = S_IDLE;
          wait_nxt  = '0;
        end else if (ready) begin
          resolve  = 1'b1;
          wait_nxt = '0;
        end else begin
          stall_raw = 1'b1;
          wait_nxt  = (wait_cnt >= WAIT_LIM) ? WAIT_LIM : wait_cnt + 1'b1;
        end
      end
      S_REDIR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        wait_nxt  = '0;
      end
    endcase
    if (resolve) begin
      state_nxt = taken ? S_REDIR : S_IDLE;
    end
  end

  // Reset forces stall low at once so the front end is released during an abort.
  assign stall = stall_raw && !reset;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      wait_err    <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      redirect <= (state_nxt == S_REDIR);
      if (stall_raw && (wait_nxt == WAIT_LIM)) begin
        wait_err <= 1'b1;
      end
      if (resolve) begin
        if (br_cnt != '1) begin
          br_cnt <= br_cnt + 1'b1;
        end
        if (taken) begin
          redirect_pc <= br_target;
          if (taken_cnt != '1) begin
            taken_cnt <= taken_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the branch resolution rules.
module tb_branch_ctrl;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             br_valid;
  logic [2:0]       br_op;
  logic [31:0]      rs_val, rt_val, br_target;
  logic             rs_rdy, rt_rdy;
  logic             stall, redirect, busy, wait_err;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit          m_redir;
  int          m_waited;
  bit          m_err;
  int          m_br, m_tk;
  logic [31:0] m_pc;

  branch_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
    .rs_val(rs_val), .rt_val(rt_val), .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
    .br_target(br_target), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .wait_err(wait_err),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = rs;
    case (op)
      3'd1:    return rs == rt;
      3'd2:    return rs != rt;
      3'd3:    return s <= 0;
      3'd4:    return s > 0;
      3'd5:    return s < 0;
      3'd6:    return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_redir = 0; m_waited = 0; m_err = 0; m_br = 0; m_tk = 0; m_pc = '0;
  endtask

  task automatic check_all(input bit e_stall);
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
    chk("redirect_pc", redirect_pc, m_pc);
    chk("busy", {31'd0, busy}, {31'd0, (m_redir || m_waited > 0)});
    chk("wait_err", {31'd0, wait_err}, {31'd0, m_err});
    chk("br_cnt", 32'(br_cnt), 32'(m_br));
    chk("taken_cnt", 32'(taken_cnt), 32'(m_tk));
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model across the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsr, input logic rtr, input logic [31:0] tgt);
    bit act, rdy, e_stall;
    @(negedge clk);
    br_valid = v; br_op = op; rs_val = rs; rt_val = rt; rs_rdy = rsr; rt_rdy = rtr; br_target = tgt;
    #1;
    act = v && (op >= 3'd1) && (op <= 3'd6);
    rdy = (op == 3'd1 || op == 3'd2) ? (rsr && rtr) : rsr;
    e_stall = !m_redir && act && !rdy;
    check_all(e_stall);
    if (m_redir) begin
      m_redir = 0;
    end else if (act && rdy) begin
      m_waited = 0;
      if (m_br < CMAX) m_br++;
      if (ref_taken(op, rs, rt)) begin
        if (m_tk < CMAX) m_tk++;
        m_pc = tgt;
        m_redir = 1;
      end
    end else if (act) begin
      m_waited = (m_waited + 1 > WAIT_MAX) ? WAIT_MAX : m_waited + 1;
      if (m_waited == WAIT_MAX) m_err = 1;
    end else begin
      m_waited = 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    br_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    br_valid = 1'b0; br_op = '0; rs_val = '0; rt_val = '0;
    rs_rdy = 1'b0; rt_rdy = 1'b0; br_target = '0;
    model_reset();
    #12;
    check_all(1'b0);
    @(negedge clk);
    reset = 1'b0;

    // taken BEQ, zero-bubble resolve then one-cycle redirect
    step(1'b1, 3'd1, 32'h1234, 32'h1234, 1'b1, 1'b1, 32'h0040_0020);
    idle();
    chk("beq_redirect_pc", redirect_pc, 32'h0040_0020);
    idle();

    // BGTZ on a negative operand is not taken, BLTZ is
    step(1'b1, 3'd4, 32'h8000_0000, '0, 1'b1, 1'b0, 32'h0000_1000);
    step(1'b1, 3'd5, 32'h8000_0000, '0, 1'b1, 1'b0, 32'h0000_2000);
    idle();
    chk("bltz_cnt", 32'(taken_cnt), 32'd2);
    idle();

    // BNE waiting three cycles on rt
    for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 32'h5, 32'h6, 1'b1, 1'b0, 32'h0000_3000);
    step(1'b1, 3'd2, 32'h5, 32'h6, 1'b1, 1'b1, 32'h0000_3000);
    idle();
    idle();

    // hazard timeout: rs held not ready for 10 cycles, then squash
    for (int i = 0; i < 10; i++) step(1'b1, 3'd3, 32'h0, '0, 1'b0, 1'b1, 32'h0000_4000);
    idle();
    chk("wait_err_sticky", {31'd0, wait_err}, 32'd1);
    chk("squash_br_cnt", 32'(br_cnt), 32'd4);
    idle();

    // asynchronous reset while in WAIT
    step(1'b1, 3'd2, 32'h1, 32'h2, 1'b1, 1'b0, 32'h0000_5000);
    step(1'b1, 3'd2, 32'h1, 32'h2, 1'b1, 1'b0, 32'h0000_5000);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(1'b0);
    br_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic in short chunks so the 4-bit counters stay informative
    for (int c = 0; c < 12; c++) begin
      int rdy_pct;
      rdy_pct = (c % 3 == 0) ? 15 : 70;
      for (int n = 0; n < 25; n++) begin
        logic [31:0] rs, rt;
        int sel;
        rt = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        sel = $urandom_range(0, 3);
        rs = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 : (sel == 2) ? rt : $urandom;
        step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), rs, rt,
             $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < rdy_pct, $urandom);
      end
      do_reset();
    end

    // saturation: more than 2^CNT_W taken branches
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 3'd6, 32'h7, '0, 1'b1, 1'b1, 32'h1000 + 32'(i));
      idle();
    end
    chk("br_cnt_sat", 32'(br_cnt), 32'hF);
    chk("taken_cnt_sat", 32'(taken_cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
